// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the Gray-code sequence source.
//   state_t  : stream FSM states (IDLE, RUN, DRAIN)
//   GRAY_W   : default code width
//   FUNC_W   : working width of the conversion helpers; callers zero-extend
//              their operand into it and size-cast the result back down
//   bin2gray : binary -> reflected Gray
//   gray2bin : reflected Gray -> binary (prefix XOR from the MSB down)
// ---------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_W = 4;
    localparam int FUNC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits contribute nothing to the running XOR,
    // so a narrow code converts correctly inside the wide helper.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b = '0;
        b[FUNC_W-1] = g[FUNC_W-1];
        for (int i = FUNC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sequence_source_gray_step.sv
// ---------------------------------------------------------------------------
// gray_step
// Combinational next-code generator: advances a binary count by one in the
// requested direction (modulo 2**WIDTH) and returns the Gray encoding of
// the advanced count.
//   count      in   WIDTH  current binary count
//   dir        in   1      0 = up, 1 = down
//   next_count out  WIDTH  count +/- 1
//   next_gray  out  WIDTH  bin2gray(next_count)
// ---------------------------------------------------------------------------
module gray_step
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic [WIDTH-1:0] next_gray
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Step the count and encode the result; wrap-around is the natural modulo.
    always_comb begin
        if (dir) begin
            next_count = count - ONE;
        end else begin
            next_count = count + ONE;
        end
        next_gray = WIDTH'(bin2gray(FUNC_W'(next_count)));
    end

endmodule

// File: rtl/gray_sequence_source.sv
// ---------------------------------------------------------------------------
// gray_sequence_source
// Registered Gray-code stream generator with a valid/ready output.
// Keeps a binary count internally and presents its Gray code; supports
// up/down counting, a Gray-encoded preload and a one-shot full-cycle mode.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin streaming (IDLE only)
//   stop       in   1      finish after the current code is accepted
//   dir        in   1      0 = up, 1 = down, sampled per transfer
//   oneshot    in   1      stop after 2**WIDTH transfers (sampled with start)
//   load       in   1      preload request (IDLE only)
//   load_gray  in   WIDTH  preload value, Gray-encoded
//   gray_out   out  WIDTH  current Gray code
//   gray_valid out  1      gray_out is valid
//   gray_ready in   1      consumer accepts gray_out
//   wrap       out  1      pulse after a max->0 / 0->max transfer
//   busy       out  1      high in RUN and DRAIN
// ---------------------------------------------------------------------------
module gray_sequence_source
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    input  logic             gray_ready,
    output logic             wrap,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] TALLY_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] gray_r;
    logic             valid_r;
    logic             wrap_r;
    logic             busy_r;
    logic             stop_pend_r;
    logic             oneshot_r;
    logic [WIDTH-1:0] tally_r;
    logic             xfer_s;
    logic             finish_s;
    logic [WIDTH-1:0] next_count_s;
    logic [WIDTH-1:0] next_gray_s;

    gray_step #(.WIDTH(WIDTH)) u_step (
        .count      (count_r),
        .dir        (dir),
        .next_count (next_count_s),
        .next_gray  (next_gray_s)
    );

    // Transfer detection and next-state selection.
    // tally_r holds the number of codes already accepted in this run, so the
    // 2**WIDTH-th transfer is the one that happens while it reads all ones.
    always_comb begin
        state_next_s = state_r;
        xfer_s       = valid_r & gray_ready;
        finish_s     = xfer_s & (stop_pend_r | stop | (oneshot_r & (tally_r == MAX_COUNT)));
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (finish_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, count, code and flag registers. valid/busy are registered from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= ZERO_COUNT;
            gray_r      <= ZERO_COUNT;
            valid_r     <= 1'b0;
            wrap_r      <= 1'b0;
            busy_r      <= 1'b0;
            stop_pend_r <= 1'b0;
            oneshot_r   <= 1'b0;
            tally_r     <= ZERO_COUNT;
        end else begin
            state_r <= state_next_s;
            valid_r <= (state_next_s == RUN);
            busy_r  <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    wrap_r <= 1'b0;
                    // load is applied before start, so a same-cycle start streams load_gray first
                    if (load) begin
                        count_r <= WIDTH'(gray2bin(FUNC_W'(load_gray)));
                        gray_r  <= load_gray;
                    end
                    if (start) begin
                        tally_r     <= ZERO_COUNT;
                        oneshot_r   <= oneshot;
                        stop_pend_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (xfer_s) begin
                        count_r     <= next_count_s;
                        gray_r      <= next_gray_s;
                        tally_r     <= tally_r + TALLY_ONE;
                        wrap_r      <= (!dir && (count_r == MAX_COUNT)) ||
                                       (dir && (count_r == ZERO_COUNT));
                        stop_pend_r <= (stop_pend_r | stop) & ~finish_s;
                    end else begin
                        wrap_r      <= 1'b0;
                        stop_pend_r <= stop_pend_r | stop;
                    end
                end
                DRAIN: begin
                    wrap_r      <= 1'b0;
                    stop_pend_r <= 1'b0;
                end
                default: begin
                    wrap_r      <= 1'b0;
                    stop_pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign gray_out   = gray_r;
    assign gray_valid = valid_r;
    assign wrap       = wrap_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_gray_sequence_source.sv
// ---------------------------------------------------------------------------
// tb_gray_sequence_source
// Directed bench for gray_sequence_source (WIDTH=4). Expected codes are
// queued when a stream is launched and popped by a monitor on every
// transfer; state/flag checks are made between edges.
// ---------------------------------------------------------------------------
module tb_gray_sequence_source;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       dir;
    logic       oneshot;
    logic       load;
    logic [3:0] load_gray;
    logic [3:0] gray_out;
    logic       gray_valid;
    logic       gray_ready;
    logic       wrap;
    logic       busy;

    logic [3:0] exp_q[$];
    int         checks;
    int         errors;
    int         xfer_cnt;
    int         wrap_cnt;
    int         base;
    int         wbase;

    gray_sequence_source #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .oneshot    (oneshot),
        .load       (load),
        .load_gray  (load_gray),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .gray_ready (gray_ready),
        .wrap       (wrap),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference Gray code of n (mod 16).
    function automatic logic [3:0] g(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int target, input string tag);
        int n;
        n = 0;
        while (xfer_cnt < target && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(xfer_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && gray_valid && gray_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_xfer observed=%b expected=none", gray_out);
            end else begin
                check("scoreboard", 32'(gray_out), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && wrap) begin
            wrap_cnt++;
        end
    end

    initial begin
        checks = 0; errors = 0; xfer_cnt = 0; wrap_cnt = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; oneshot = 1'b0;
        load = 1'b0; load_gray = 4'b0000; gray_ready = 1'b1;
        #12;
        check("rst_gray", 32'(gray_out), 32'h0);
        check("rst_valid", 32'(gray_valid), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: full up cycle with wrap, then stop
        for (int i = 0; i <= 16; i++) exp_q.push_back(g(i));
        base = xfer_cnt; wbase = wrap_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("t1_valid", 32'(gray_valid), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        wait_xfers(base + 16, "t1_wait16");
        check("t1_wrap_pulse", 32'(wrap), 32'h1);
        check("t1_code_wrapped", 32'(gray_out), 32'h0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t1_drain_valid", 32'(gray_valid), 32'h0);
        check("t1_drain_busy", 32'(busy), 32'h1);
        check("t1_drain_code", 32'(gray_out), 32'(g(1)));
        tick();
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_wrap_count", 32'(wrap_cnt - wbase), 32'h1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'h0);

        // 2: count down from 0, reverse after three transfers
        do_reset();
        exp_q.push_back(g(0));  exp_q.push_back(g(15)); exp_q.push_back(g(14));
        exp_q.push_back(g(13)); exp_q.push_back(g(14));
        base = xfer_cnt; wbase = wrap_cnt;
        dir = 1'b1; start = 1'b1; tick(); start = 1'b0;
        wait_xfers(base + 1, "t2_wait1");
        check("t2_wrap_down", 32'(wrap), 32'h1);
        wait_xfers(base + 3, "t2_wait3");
        check("t2_code_13", 32'(gray_out), 32'(4'b1011));
        dir = 1'b0;
        wait_xfers(base + 4, "t2_wait4");
        stop = 1'b1; tick(); stop = 1'b0;
        check("t2_drain_valid", 32'(gray_valid), 32'h0);
        check("t2_drain_code", 32'(gray_out), 32'(4'b1000));
        tick();
        check("t2_wrap_count", 32'(wrap_cnt - wbase), 32'h1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'h0);

        // 3: stall on 0110 with stop during the stall
        do_reset();
        for (int i = 0; i <= 4; i++) exp_q.push_back(g(i));
        base = xfer_cnt;
        start = 1'b1; tick(); start = 1'b0;
        wait_xfers(base + 4, "t3_wait4");
        gray_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) stop = 1'b1;
            tick();
            stop = 1'b0;
            check("t3_stall_code", 32'(gray_out), 32'(4'b0110));
            check("t3_stall_valid", 32'(gray_valid), 32'h1);
        end
        gray_ready = 1'b1;
        tick();
        check("t3_drain_valid", 32'(gray_valid), 32'h0);
        check("t3_drain_busy", 32'(busy), 32'h1);
        check("t3_drain_code", 32'(gray_out), 32'(4'b0111));
        tick();
        check("t3_idle_busy", 32'(busy), 32'h0);
        tick();
        check("t3_stays_idle", 32'(gray_valid), 32'h0);
        check("t3_queue_empty", 32'(exp_q.size()), 32'h0);

        // 4: load+start together; load during RUN ignored.
        // gray2bin(1101)=9, so counting up gives 10 (1111) then 11 (1110).
        exp_q.push_back(4'b1101); exp_q.push_back(4'b1111); exp_q.push_back(4'b1110);
        base = xfer_cnt;
        load = 1'b1; load_gray = 4'b1101; start = 1'b1; tick();
        load = 1'b0; start = 1'b0;
        check("t4_first_code", 32'(gray_out), 32'(4'b1101));
        wait_xfers(base + 1, "t4_wait1");
        load = 1'b1; load_gray = 4'b0000; tick(); load = 1'b0;
        check("t4_load_ignored", 32'(gray_out), 32'(4'b1110));
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_drain_valid", 32'(gray_valid), 32'h0);
        check("t4_drain_code", 32'(gray_out), 32'(4'b1010));
        tick();
        check("t4_queue_empty", 32'(exp_q.size()), 32'h0);

        // 5: oneshot full cycle
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(g(i));
        base = xfer_cnt;
        oneshot = 1'b1; start = 1'b1; tick(); oneshot = 1'b0; start = 1'b0;
        wait_xfers(base + 16, "t5_wait16");
        check("t5_valid_low", 32'(gray_valid), 32'h0);
        check("t5_code_wrapped", 32'(gray_out), 32'h0);
        check("t5_wrap", 32'(wrap), 32'h1);
        check("t5_drain_busy", 32'(busy), 32'h1);
        tick();
        check("t5_idle_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        check("t5_count16", 32'(xfer_cnt - base), 32'd16);
        check("t5_queue_empty", 32'(exp_q.size()), 32'h0);

        // 6: asynchronous reset mid-stream, then restart from 0000
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(g(i));
        base = xfer_cnt;
        start = 1'b1; tick(); start = 1'b0;
        wait_xfers(base + 3, "t6_wait3");
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_gray", 32'(gray_out), 32'h0);
        check("t6_rst_valid", 32'(gray_valid), 32'h0);
        check("t6_rst_wrap", 32'(wrap), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        #3 rst_n = 1'b1;
        tick();
        check("t6_post_valid", 32'(gray_valid), 32'h0);
        exp_q.push_back(g(0)); exp_q.push_back(g(1));
        base = xfer_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("t6_restart_code", 32'(gray_out), 32'h0);
        wait_xfers(base + 1, "t6_wait1");
        stop = 1'b1; tick(); stop = 1'b0;
        check("t6_drain_valid", 32'(gray_valid), 32'h0);
        tick(); tick();
        check("t6_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
